// File: rtl/ex_div_seq_pkg.sv
// Shared definitions for the EX-stage divide sequencer: state codes, handshake
// levels, bus widths and the aluop codes that select signed or unsigned divide.
package ex_div_seq_pkg;

  localparam int DivDataW      = 32;
  localparam int DoubleRegBusW = 2 * DivDataW;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  function automatic logic is_signed_div(input logic [7:0] aluop);
    return aluop == EXE_DIV_OP;
  endfunction

endpackage

// File: rtl/ex_div_seq_if.sv
// Handshake and operand bundle between EX (master) and the divide sequencer (slave).
interface ex_div_seq_if
  import ex_div_seq_pkg::*;
#(
  parameter int DATA_W = DivDataW
);

  logic                  signed_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  modport master (
    output signed_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/ex_div_seq_div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module ex_div_seq_div_step
  import ex_div_seq_pkg::*;
#(
  parameter int DATA_W = DivDataW
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // The extra top bit of the trial difference is the borrow: set means the
  // shifted remainder was smaller than the divisor and must be restored.
  always_comb begin
    shifted = {rem_i, quo_i[DATA_W-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (!trial[DATA_W]) begin
      rem_o = trial[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o = shifted[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_seq.sv
// Multi-cycle DIV/DIVU sequencer: stalls EX while a restoring divide runs one
// step per clock, then presents {remainder, quotient} until EX drops start.
module ex_div_seq
  import ex_div_seq_pkg::*;
#(
  parameter int DATA_W = DivDataW
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_div_seq_if.slave bus
);

  localparam int CntW = $clog2(DATA_W) + 1;

  div_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     quo_q, quo_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  sign1_q, sign1_d;
  logic                  sign2_q, sign2_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W-1:0]     op1_mag, op2_mag;
  logic [DATA_W-1:0]     step_rem, step_quo;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

  ex_div_seq_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Magnitudes feed the unsigned core; the latched signs restore the result.
  // Negating 0x80000000 wraps to itself, giving the non-trapping overflow result.
  always_comb begin
    op1_mag = (bus.signed_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    op2_mag = (bus.signed_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
    quo_fix = (sign1_q ^ sign2_q) ? -step_quo : step_quo;
    rem_fix = sign1_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = op1_mag;
            divisor_d = op2_mag;
            sign1_d   = bus.signed_i & bus.opdata1_i[DATA_W-1];
            sign2_d   = bus.signed_i & bus.opdata2_i[DATA_W-1];
          end
        end
      end
      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
        ready_d  = DivResultReady;
      end
      DivOn: begin
        if (bus.annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(DATA_W - 1)) begin
            state_d  = DivEnd;
            result_d = {rem_fix, quo_fix};
            ready_d  = DivResultReady;
          end
        end
      end
      DivEnd: begin
        if (!bus.start_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q;

endmodule
